// File: rtl/fifo_pkg.sv
// Shared types and defaults for the lab FIFO blocks (control, RAM, reader).
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 5;

  // Output-buffer occupancy, 0..2 words.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_reader_if.sv
// Pop/read-data side of the FIFO plus the downstream valid/ready stream.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int unsigned width = FIFO_WIDTH_DEF
);

  logic             fifo_empty;
  logic             fifo_rd;
  logic [width-1:0] fifo_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  // master: the reader engine; slave: FIFO control/RAM and consumer side.
  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  out_ready,
    output fifo_rd,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output out_ready,
    input  fifo_rd,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order register buffer; entry 0 is always the head word.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int unsigned width = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] head,
  output occ_t             occ
);

  logic [width-1:0] ent0;
  logic [width-1:0] ent1;
  occ_t             occ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= OCC_EMPTY;
      ent0  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      occ_q <= OCC_EMPTY;
    end else begin
      unique case ({wr, pop})
        2'b10: begin
          if (occ_q == OCC_EMPTY) ent0 <= wdata;
          else                    ent1 <= wdata;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Capture and retire together: shift, new word lands behind the survivor.
          if (occ_q == OCC_ONE) begin
            ent0 <= wdata;
          end else begin
            ent0 <= ent1;
            ent1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (occ_q != OCC_EMPTY) ? ent0 : '0;
  assign occ  = occ_q;

  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(wr && !pop && !flush && (occ_q == OCC_FULL)));

endmodule

// File: rtl/fifo_reader.sv
// FIFO drain engine: credit-checked pops, one-cycle RAM capture, valid/ready output.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned width = FIFO_WIDTH_DEF,
  parameter int unsigned cnt_w = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic [cnt_w-1:0] words_out,
  fifo_reader_if.master    bus
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic       wr;
  logic [2:0] credit_used;

  assign bus.out_valid = (occ != OCC_EMPTY);
  assign pop           = bus.out_valid && bus.out_ready;

  // In-flight word counts as occupied so the buffer can never overflow.
  always_comb begin
    credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    bus.fifo_rd = reset && !bus.fifo_empty && !flush && (credit_used < 3'd2);
  end

  assign wr = inflight && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_out <= '0;
    end else if (pop) begin
      words_out <= words_out + cnt_w'(1);
    end
  end

  fifo_reader_buf #(
    .width(width)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .wr   (wr),
    .wdata(bus.fifo_rdata),
    .pop  (pop),
    .head (bus.out_data),
    .occ  (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench: queue-based FIFO/consumer model with directed and random steps.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] words_out;

  fifo_reader_if #(.width(W)) bus ();

  fifo_reader #(
    .width(W),
    .cnt_w(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .words_out(words_out),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] src_q[$];   // words still held by the FIFO
  logic [W-1:0] exp_q[$];   // words delivered by the RAM, not yet accepted
  bit           pending;
  logic [W-1:0] pending_word;
  int unsigned  acc_cnt;
  int           checks = 0;
  int           errors = 0;
  int           rd_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance FIFO/consumer model.
  task automatic step(input bit rdy, input bit fl);
    bit pop_m;
    bit rd_m;
    bit rd_seen;
    bus.fifo_empty = (src_q.size() == 0);
    bus.out_ready  = rdy;
    flush          = fl;
    #1;
    pop_m = (exp_q.size() != 0) && rdy;
    rd_m  = !bus.fifo_empty && !fl &&
            ((int'(exp_q.size()) + int'(pending) - int'(pop_m)) < 2);
    check("out_valid", bus.out_valid, (exp_q.size() != 0));
    check("out_data", bus.out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
    check("words_out", words_out, acc_cnt[CW-1:0]);
    check("fifo_rd", bus.fifo_rd, rd_m);
    rd_seen = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (pop_m) begin
      void'(exp_q.pop_front());
      acc_cnt++;
    end
    if (fl) exp_q.delete();
    else if (pending) exp_q.push_back(pending_word);
    pending = rd_seen;
    if (rd_seen) begin
      rd_pulses++;
      if (src_q.size() != 0) pending_word = src_q.pop_front();
      else                   pending_word = W'($urandom);
    end
    bus.fifo_rdata = rd_seen ? pending_word : W'($urandom);
  endtask

  initial begin
    bit rdy;
    bit fl;
    reset          = 1'b1;
    flush          = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.out_ready  = 1'b0;
    bus.fifo_rdata = '0;
    pending        = 1'b0;
    pending_word   = '0;
    acc_cnt        = 0;
    rd_pulses      = 0;

    // Reset then idle
    #1 reset = 1'b0;
    #2;
    check("rst_fifo_rd", bus.fifo_rd, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_words_out", words_out, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("idle_rd_pulses", rd_pulses, 0);

    // Single word
    rd_pulses = 0;
    src_q.push_back(4'hA);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("single_rd_pulses", rd_pulses, 1);
    check("single_words_out", words_out, 1);

    // Streaming 1..5
    rd_pulses = 0;
    for (int i = 1; i <= 5; i++) src_q.push_back(W'(i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("stream_rd_pulses", rd_pulses, 5);
    check("stream_words_out", words_out, 6);

    // Backpressure: 4 words, consumer stalled
    rd_pulses = 0;
    for (int i = 6; i <= 9; i++) src_q.push_back(W'(i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("bp_rd_pulses_stalled", rd_pulses, 2);
    check("bp_head_word", bus.out_data, 4'h6);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("bp_rd_pulses_total", rd_pulses, 4);
    check("bp_words_out", words_out, 10);

    // Flush with a word buffered, one in flight, and a pop in the flush cycle
    for (int i = 10; i <= 14; i++) src_q.push_back(W'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("flush_words_out", words_out, 14);

    // Reset mid-stream with the buffer full
    for (int i = 1; i <= 4; i++) src_q.push_back(W'(i + 2));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("pre_rst_out_valid", bus.out_valid, 1'b1);
    check("pre_rst_fifo_rd", bus.fifo_rd, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_fifo_rd", bus.fifo_rd, 1'b0);
    check("midrst_out_data", bus.out_data, '0);
    check("midrst_words_out", words_out, '0);
    exp_q.delete();
    pending = 1'b0;
    acc_cnt = 0;
    @(posedge clk);
    #1;
    check("midrst_hold_valid", bus.out_valid, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("post_rst_words_out", words_out, 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 6 && $urandom_range(0, 1) == 1) src_q.push_back(W'($urandom));
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      step(rdy, fl);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check("drain_out_valid", bus.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
